uart_tx_serializer: RTL and testbench

//  UART transmit engine directly downstream of the APB UART bridge. Consumes the bridge's

---
 rtl/uart_tx_serializer_if.sv | 42 ++++
 rtl/uart_tx_serializer.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Handshake between the APB UART bridge and the UART transmit serializer.
//   send           bridge -> serializer  level; a rising edge requests one frame
//   DATA_TX        bridge -> serializer  byte to transmit
//   parity_type    bridge -> serializer  00/11 none, 01 odd, 10 even
//   baud_rate      bridge -> serializer  selects one of four bit periods
//   tx             serializer -> line    serial output, idle high
//   tx_active_flag serializer -> bridge  high while a frame is on the line
//   tx_done_flag   serializer -> bridge  one-cycle pulse at end of stop bit
interface uart_tx_serializer_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;

    logic              send;
    logic [DATA_W-1:0] DATA_TX;
    logic [SEL_W-1:0]  parity_type;
    logic [SEL_W-1:0]  baud_rate;
    logic              tx;
    logic              tx_active_flag;
    logic              tx_done_flag;

    // Bridge side
    modport master (
        output send,
        output DATA_TX,
        output parity_type,
        output baud_rate,
        input  tx,
        input  tx_active_flag,
        input  tx_done_flag
    );

    // Serializer side
    modport slave (
        input  send,
        input  DATA_TX,
        input  parity_type,
        input  baud_rate,
        output tx,
        output tx_active_flag,
        output tx_done_flag
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: serializes one byte per rising edge of send as an
// 8N1 / 8E1 / 8O1 frame, LSB first, on an idle-high line.
//   PCLK     system clock, rising edge
//   PRESETn  asynchronous active-low reset
//   bus      uart_tx_serializer_if.slave (send/DATA_TX/parity_type/baud_rate
//            in; tx/tx_active_flag/tx_done_flag out, all registered)
module uart_tx_serializer #(
    parameter int unsigned DIV_0 = 20833,
    parameter int unsigned DIV_1 = 10417,
    parameter int unsigned DIV_2 = 5208,
    parameter int unsigned DIV_3 = 2604,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    uart_tx_serializer_if.slave   bus
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned SEL_W  = 2;

    localparam logic [CNT_W-1:0] TC_0 = CNT_W'(DIV_0 - 1);
    localparam logic [CNT_W-1:0] TC_1 = CNT_W'(DIV_1 - 1);
    localparam logic [CNT_W-1:0] TC_2 = CNT_W'(DIV_2 - 1);
    localparam logic [CNT_W-1:0] TC_3 = CNT_W'(DIV_3 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state_q,   state_nx;
    logic [CNT_W-1:0]    cnt_q,     cnt_nx;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_nx;
    logic [DATA_W-1:0]   data_q,    data_nx;
    logic [SEL_W-1:0]    par_q,     par_nx;
    logic [SEL_W-1:0]    baud_q,    baud_nx;
    logic                tx_q,      tx_nx;
    logic                active_q,  active_nx;
    logic                done_q,    done_nx;
    logic                send_d_q;
    logic                primed_q;

    logic                start_c;
    logic                tc_c;
    logic [CNT_W-1:0]    tc_val_c;
    logic                par_en_c;
    logic                par_bit_c;
    logic [IDX_W-1:0]    next_idx_c;

    // primed_q blocks the first cycle after reset, when send_d_q still holds
    // its reset value rather than a sampled send; a send already high at
    // release must not look like a rising edge.
    assign start_c    = bus.send & ~send_d_q & primed_q;

    // Terminal count for the latched baud selection
    always_comb begin
        tc_val_c = TC_0;
        unique case (baud_q)
            2'b00:   tc_val_c = TC_0;
            2'b01:   tc_val_c = TC_1;
            2'b10:   tc_val_c = TC_2;
            default: tc_val_c = TC_3;
        endcase
    end

    assign tc_c       = (cnt_q == tc_val_c);
    assign par_en_c   = par_q[0] ^ par_q[1];
    // Even: XOR of data; odd (01): inverted
    assign par_bit_c  = (^data_q) ^ par_q[0];
    assign next_idx_c = bit_idx_q + IDX_W'(1);

    // Next-state and next-output logic; tx is produced one step ahead so the
    // line changes on the same edge as the state.
    always_comb begin
        state_nx   = state_q;
        cnt_nx     = cnt_q;
        bit_idx_nx = bit_idx_q;
        data_nx    = data_q;
        par_nx     = par_q;
        baud_nx    = baud_q;
        tx_nx      = tx_q;
        active_nx  = active_q;
        done_nx    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_c) begin
                    data_nx    = bus.DATA_TX;
                    par_nx     = bus.parity_type;
                    baud_nx    = bus.baud_rate;
                    state_nx   = START;
                    cnt_nx     = '0;
                    bit_idx_nx = '0;
                    tx_nx      = 1'b0;
                    active_nx  = 1'b1;
                end
            end
            START: begin
                if (tc_c) begin
                    cnt_nx     = '0;
                    bit_idx_nx = '0;
                    state_nx   = DATA;
                    tx_nx      = data_q[0];
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (tc_c) begin
                    cnt_nx = '0;
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        if (par_en_c) begin
                            state_nx = PARITY;
                            tx_nx    = par_bit_c;
                        end else begin
                            state_nx = STOP;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        bit_idx_nx = next_idx_c;
                        tx_nx      = data_q[next_idx_c];
                    end
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (tc_c) begin
                    cnt_nx   = '0;
                    state_nx = STOP;
                    tx_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (tc_c) begin
                    cnt_nx    = '0;
                    state_nx  = IDLE;
                    tx_nx     = 1'b1;
                    active_nx = 1'b0;
                    done_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_nx  = IDLE;
                cnt_nx    = '0;
                tx_nx     = 1'b1;
                active_nx = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            par_q     <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            send_d_q  <= 1'b0;
            primed_q  <= 1'b0;
        end else begin
            state_q   <= state_nx;
            cnt_q     <= cnt_nx;
            bit_idx_q <= bit_idx_nx;
            data_q    <= data_nx;
            par_q     <= par_nx;
            baud_q    <= baud_nx;
            tx_q      <= tx_nx;
            active_q  <= active_nx;
            done_q    <= done_nx;
            send_d_q  <= bus.send;
            primed_q  <= 1'b1;
        end
    end

    assign bus.tx             = tx_q;
    assign bus.tx_active_flag = active_q;
    assign bus.tx_done_flag   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed, table-driven bench for uart_tx_serializer built with short bit
// periods (16/8/4/2 clocks) so whole frames can be checked cycle by cycle.
module tb_uart_tx_serializer;

    logic clk;
    logic rst_n;

    uart_tx_serializer_if intf ();

    uart_tx_serializer #(
        .DIV_0 (16),
        .DIV_1 (8),
        .DIV_2 (4),
        .DIV_3 (2),
        .CNT_W (16)
    ) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  par;
        logic [1:0]  baud;
        int          div;
        int          nbits;
        logic [10:0] bits;   // line bit i at position i: start, d0..d7, [parity], stop
    } vec_t;

    vec_t vecs [8];
    int   n_vec;
    int   n_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Line must stay idle (tx high, no flags) for the given number of cycles.
    task automatic idle_check(input int cycles, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (intf.tx !== 1'b1 || intf.tx_active_flag !== 1'b0 || intf.tx_done_flag !== 1'b0)
                bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    // Request one frame and check every cycle of it. hold keeps send high;
    // disturb re-raises send and changes DATA_TX/baud_rate at line bit 4.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b,
                             input int div, input int nbits, input logic [10:0] exp,
                             input bit hold, input bit disturb, input string name);
        logic [10:0] got;
        bit          unstable;
        bit          overlap;
        int          act_cnt;
        int          done_cnt;
        int          done_at;
        int          k;
        got      = '0;
        unstable = 1'b0;
        overlap  = 1'b0;
        act_cnt  = 0;
        done_cnt = 0;
        done_at  = -1;
        @(posedge clk); #1;
        intf.send = 1'b0;
        @(posedge clk); #1;
        intf.DATA_TX     = d;
        intf.parity_type = p;
        intf.baud_rate   = b;
        intf.send        = 1'b1;
        for (int t = 0; t <= nbits * div; t++) begin
            @(posedge clk); #1;
            if (t == 0)
                chk({name, " start_latency"}, 32'(intf.tx), 32'd0);
            if (t < nbits * div) begin
                k = t / div;
                if (t % div == 0)
                    got[k] = intf.tx;
                else if (intf.tx !== got[k])
                    unstable = 1'b1;
            end
            if (intf.tx_active_flag === 1'b1)
                act_cnt++;
            if (intf.tx_done_flag === 1'b1) begin
                done_cnt++;
                if (done_at < 0)
                    done_at = t;
            end
            if (intf.tx_active_flag === 1'b1 && intf.tx_done_flag === 1'b1)
                overlap = 1'b1;
            if (!hold && t == 2)
                intf.send = 1'b0;
            if (disturb && t == 4 * div) begin
                intf.send      = 1'b1;
                intf.DATA_TX   = ~d;
                intf.baud_rate = b ^ 2'b01;
            end
        end
        chk({name, " bits"}, {20'd0, unstable, got}, {20'd0, 1'b0, exp});
        chk({name, " done_at"}, 32'(done_at), 32'(nbits * div));
        chk({name, " done_count"}, 32'(done_cnt), 32'd1);
        chk({name, " active_cycles"}, 32'(act_cnt), 32'(nbits * div));
        chk({name, " flag_overlap"}, 32'(overlap), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        //            data   par    baud   div nb  line bits
        vecs[0] = '{8'hA5, 2'b00, 2'b00, 16, 10, 11'h34A};
        vecs[1] = '{8'h07, 2'b10, 2'b00, 16, 11, 11'h60E};
        vecs[2] = '{8'h07, 2'b01, 2'b00, 16, 11, 11'h40E};
        vecs[3] = '{8'h3C, 2'b11, 2'b01,  8, 10, 11'h278};
        vecs[4] = '{8'h00, 2'b10, 2'b10,  4, 11, 11'h400};
        vecs[5] = '{8'hFF, 2'b01, 2'b11,  2, 11, 11'h7FE};
        vecs[6] = '{8'h5A, 2'b10, 2'b11,  2, 11, 11'h4B4};
        vecs[7] = '{8'h81, 2'b00, 2'b10,  4, 10, 11'h302};

        // Reset values
        rst_n            = 1'b0;
        intf.send        = 1'b0;
        intf.DATA_TX     = 8'h00;
        intf.parity_type = 2'b00;
        intf.baud_rate   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset tx", 32'(intf.tx), 32'd1);
        chk("reset active", 32'(intf.tx_active_flag), 32'd0);
        chk("reset done", 32'(intf.tx_done_flag), 32'd0);
        rst_n = 1'b1;
        idle_check(5, "post_reset idle");

        // Table: every format and every baud setting, frames back to back
        for (int i = 0; i < 8; i++)
            run_frame(vecs[i].data, vecs[i].par, vecs[i].baud, vecs[i].div,
                      vecs[i].nbits, vecs[i].bits, 1'b0, 1'b0, $sformatf("vec%0d", i));

        // send held high for three frame times: a single frame only
        run_frame(8'hA5, 2'b00, 2'b00, 16, 10, 11'h34A, 1'b1, 1'b0, "hold");
        idle_check(3 * 10 * 16, "hold no_retrigger");
        intf.send = 1'b0;

        // Edge and input changes mid-frame are ignored
        run_frame(8'hC3, 2'b10, 2'b00, 16, 11, 11'h586, 1'b0, 1'b1, "disturb");
        idle_check(48, "disturb no_queued_frame");
        intf.send      = 1'b0;
        intf.baud_rate = 2'b00;

        // Reset during data bit 3, send left high through release
        @(posedge clk); #1;
        intf.send = 1'b0;
        @(posedge clk); #1;
        intf.DATA_TX     = 8'hA5;
        intf.parity_type = 2'b00;
        intf.baud_rate   = 2'b00;
        intf.send        = 1'b1;
        repeat (70) @(posedge clk);
        #1;
        chk("pre_reset active", 32'(intf.tx_active_flag), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset tx", 32'(intf.tx), 32'd1);
        chk("midreset active", 32'(intf.tx_active_flag), 32'd0);
        chk("midreset done", 32'(intf.tx_done_flag), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_check(40, "release send_high no_frame");
        run_frame(8'hA5, 2'b00, 2'b00, 16, 10, 11'h34A, 1'b0, 1'b0, "after_reset");

        // Back-to-back at the shortest bit period
        run_frame(8'h96, 2'b00, 2'b11, 2, 10, 11'h32C, 1'b0, 1'b0, "b2b_a");
        run_frame(8'h69, 2'b01, 2'b11, 2, 11, 11'h6D2, 1'b0, 1'b0, "b2b_b");
        idle_check(10, "final idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
